// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipelined CPU stages.
//   - opcode / funct constants for the supported MIPS subset
//   - 4-bit ALU op encoding consumed by execute
//   - ctrl_t: decoded control word for the instruction in ID
//   - idex_t: contents of the ID/EX pipeline register
//   - decode(): instruction word -> ctrl_t
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_NOR = 4'd4,
    ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_LUI = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic    regwrite;
    logic    memtoreg;
    logic    memread;
    logic    memwrite;
    logic    alusrc;
    alu_op_e aluop;
    logic    dst_rt;   // destination is rt (I-type) instead of rd
    logic    rt_src;   // rt is read as a source operand
    logic    zext;     // zero-extend the immediate
    logic    is_beq;
    logic    is_bne;
    logic    is_j;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pcplus;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  waddr;
    logic [4:0]  shamt;
    alu_op_e     aluop;
    logic        alusrc;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
  } idex_t;

  // Unknown opcodes/functs and the all-zero NOP fall through as all-zero control.
  function automatic ctrl_t decode(input logic [31:0] ir);
    ctrl_t c;
    c = '0;
    case (ir[31:26])
      OP_RTYPE: if (ir != NOP) begin
        c.regwrite = 1'b1;
        c.rt_src   = 1'b1;
        case (ir[5:0])
          F_ADD, F_ADDU: c.aluop = ALU_ADD;
          F_SUB, F_SUBU: c.aluop = ALU_SUB;
          F_AND:         c.aluop = ALU_AND;
          F_OR:          c.aluop = ALU_OR;
          F_NOR:         c.aluop = ALU_NOR;
          F_SLT:         c.aluop = ALU_SLT;
          F_SLL:         c.aluop = ALU_SLL;
          F_SRL:         c.aluop = ALU_SRL;
          default: begin
            c.regwrite = 1'b0;
            c.rt_src   = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst_rt = 1'b1; c.aluop = ALU_ADD;
      end
      OP_SLTI: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst_rt = 1'b1; c.aluop = ALU_SLT;
      end
      OP_ANDI: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst_rt = 1'b1; c.zext = 1'b1; c.aluop = ALU_AND;
      end
      OP_ORI: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst_rt = 1'b1; c.zext = 1'b1; c.aluop = ALU_OR;
      end
      OP_LUI: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst_rt = 1'b1; c.zext = 1'b1; c.aluop = ALU_LUI;
      end
      OP_LW: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst_rt = 1'b1;
        c.memread  = 1'b1; c.memtoreg = 1'b1; c.aluop = ALU_ADD;
      end
      OP_SW: begin
        c.alusrc = 1'b1; c.memwrite = 1'b1; c.rt_src = 1'b1; c.aluop = ALU_ADD;
      end
      OP_BEQ: begin c.is_beq = 1'b1; c.rt_src = 1'b1; end
      OP_BNE: begin c.is_bne = 1'b1; c.rt_src = 1'b1; end
      OP_J:   c.is_j = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile.sv
// regfile: RF_DEPTH x 32 register file, r0 hardwired to zero.
//   clk, rst   : clock, synchronous active-high clear of every register
//   raddr/rdata: two combinational read ports (index 0 = rs, 1 = rt)
//   we/waddr/wdata: write port, written on the rising edge
// A read of the register being written this cycle returns wdata, so the
// ID stage sees writeback results without an extra bypass.
module regfile
  import pipe_pkg::*;
#(
  parameter int RF_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0][4:0] raddr,
  output logic [1:0][31:0] rdata,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [31:0]     wdata
);

  logic [31:0] regs [RF_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (raddr[p] == '0)                rdata[p] = '0;
      else if (we && waddr == raddr[p])  rdata[p] = wdata;
      else                               rdata[p] = regs[raddr[p]];
    end
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode stage.
//   irF/pcplusF         : fetched instruction and PC+4 into IF/ID
//   wb_*                : writeback port into the register file
//   mem_regwrite/waddr  : EX/MEM destination, for branch operand hazards
//   stall/PCSrc/jump/pcchange : back to fetch (combinational)
//   ex_*                : ID/EX register contents for execute
// Branches resolve here, so a branch whose operand is still being produced
// in EX or MEM must wait; a load feeding the next instruction also waits.
module id_stage
  import pipe_pkg::*;
#(
  parameter int RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] irF,
  input  logic [31:0] pcplusF,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_waddr,
  output logic        stall,
  output logic        PCSrc,
  output logic        jump,
  output logic [31:0] pcchange,
  output logic [31:0] ex_pcplus,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_waddr,
  output logic [4:0]  ex_shamt,
  output logic [3:0]  ex_aluop,
  output logic        ex_alusrc,
  output logic        ex_regwrite,
  output logic        ex_memtoreg,
  output logic        ex_memread,
  output logic        ex_memwrite
);

  logic [31:0]       ir, pcplus;
  idex_t             ex_q, ex_d;
  ctrl_t             c;
  logic [4:0]        rs, rt, rd;
  logic [1:0][4:0]   raddr;
  logic [1:0][31:0]  rdata;
  logic              load_use, br_hazard, taken;
  logic [31:0]       imm_sx, br_tgt, j_tgt;

  // A producer targeting r0 never creates a real dependency.
  function automatic logic src_hit(input logic wr, input logic [4:0] a,
                                   input logic [4:0] s, input logic [4:0] t);
    return wr && (a != '0) && (a == s || a == t);
  endfunction

  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign raddr = {rt, rs};

  regfile #(.RF_DEPTH(RF_DEPTH)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .raddr (raddr),
    .rdata (rdata),
    .we    (wb_we),
    .waddr (wb_waddr),
    .wdata (wb_wdata)
  );

  always_comb begin
    c         = decode(ir);
    imm_sx    = {{16{ir[15]}}, ir[15:0]};
    load_use  = ex_q.memread && (ex_q.waddr == rs || (c.rt_src && ex_q.waddr == rt));
    br_hazard = (c.is_beq || c.is_bne) &&
                (src_hit(ex_q.regwrite, ex_q.waddr, rs, rt) ||
                 src_hit(mem_regwrite, mem_waddr, rs, rt));
    stall     = load_use | br_hazard;
    taken     = (c.is_beq && rdata[0] == rdata[1]) || (c.is_bne && rdata[0] != rdata[1]);
    PCSrc     = taken & ~stall;
    jump      = c.is_j & ~stall;
    br_tgt    = pcplus + {imm_sx[29:0], 2'b00};
    j_tgt     = {pcplus[31:28], ir[25:0], 2'b00};
    pcchange  = jump ? j_tgt : br_tgt;

    ex_d          = '0;
    ex_d.pcplus   = pcplus;
    ex_d.rs_data  = rdata[0];
    ex_d.rt_data  = rdata[1];
    ex_d.imm      = c.zext ? {16'h0, ir[15:0]} : imm_sx;
    ex_d.rs       = rs;
    ex_d.rt       = rt;
    ex_d.waddr    = c.regwrite ? (c.dst_rt ? rt : rd) : 5'd0;
    ex_d.shamt    = ir[10:6];
    ex_d.aluop    = c.aluop;
    ex_d.alusrc   = c.alusrc;
    ex_d.regwrite = c.regwrite;
    ex_d.memtoreg = c.memtoreg;
    ex_d.memread  = c.memread;
    ex_d.memwrite = c.memwrite;
  end

  // IF/ID: reset > stall (hold) > redirect (flush wrong-path fetch) > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir     <= NOP;
      pcplus <= '0;
    end else if (!stall) begin
      if (PCSrc || jump) begin
        ir     <= NOP;
        pcplus <= '0;
      end else begin
        ir     <= irF;
        pcplus <= pcplusF;
      end
    end
  end

  // ID/EX: a stalled instruction stays in ID, so EX receives a full bubble.
  always_ff @(posedge clk) begin
    if (rst || stall) ex_q <= '0;
    else              ex_q <= ex_d;
  end

  assign ex_pcplus   = ex_q.pcplus;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_waddr    = ex_q.waddr;
  assign ex_shamt    = ex_q.shamt;
  assign ex_aluop    = ex_q.aluop;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed test-plan sequences followed by random instruction
// streams, all compared every cycle against a mnemonic-level model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irF, pcplusF, wb_wdata;
  logic        wb_we, mem_regwrite;
  logic [4:0]  wb_waddr, mem_waddr;
  logic        stall, PCSrc, jump;
  logic [31:0] pcchange, ex_pcplus, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_waddr, ex_shamt;
  logic [3:0]  ex_aluop;
  logic        ex_alusrc, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;

  always #5 clk = ~clk;

  id_stage #(.RF_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .irF(irF), .pcplusF(pcplusF),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .mem_regwrite(mem_regwrite), .mem_waddr(mem_waddr),
    .stall(stall), .PCSrc(PCSrc), .jump(jump), .pcchange(pcchange),
    .ex_pcplus(ex_pcplus), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_waddr(ex_waddr), .ex_shamt(ex_shamt),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pcplus, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, waddr, shamt;
    logic [3:0]  aluop;
    logic        alusrc, regwrite, memtoreg, memread, memwrite;
  } mex_t;

  logic [31:0] m_ir, m_pc;
  logic [31:0] m_rf [32];
  mex_t        m_ex;

  logic [5:0] ftab [10] = '{6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [5:0] otab [11] = '{6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

  function automatic string mnem(input logic [31:0] w);
    if (w == 32'h0) return "nop";
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h00: return "sll";  6'h02: return "srl";
        6'h20: return "add";  6'h21: return "addu";
        6'h22: return "sub";  6'h23: return "subu";
        6'h24: return "and";  6'h25: return "or";
        6'h27: return "nor";  6'h2A: return "slt";
        default: return "bad";
      endcase
      6'h02: return "j";     6'h04: return "beq";   6'h05: return "bne";
      6'h08: return "addi";  6'h09: return "addiu"; 6'h0A: return "slti";
      6'h0C: return "andi";  6'h0D: return "ori";   6'h0F: return "lui";
      6'h23: return "lw";    6'h2B: return "sw";
      default: return "bad";
    endcase
  endfunction

  function automatic bit is_r(input string m);
    case (m)
      "sll", "srl", "add", "addu", "sub", "subu", "and", "or", "nor", "slt": return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit i_dest(input string m);
    case (m)
      "addi", "addiu", "slti", "andi", "ori", "lui", "lw": return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input string m);
    case (m)
      "add", "addu", "addi", "addiu", "lw", "sw": return 4'd0;
      "sub", "subu":  return 4'd1;
      "and", "andi":  return 4'd2;
      "or", "ori":    return 4'd3;
      "nor":          return 4'd4;
      "slt", "slti":  return 4'd5;
      "sll":          return 4'd6;
      "srl":          return 4'd7;
      "lui":          return 4'd8;
      default:        return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_we && wb_waddr == a) return wb_wdata;
    return m_rf[a];
  endfunction

  task automatic mreset();
    m_ir = 32'h0;
    m_pc = 32'h0;
    m_ex = '{default: 0};
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  // Compare one cycle against the model, then clock and advance the model.
  task automatic cyc();
    string m;
    logic [4:0] rs, rt, rd;
    logic [31:0] a, b, btgt, jtgt, e_pcc;
    logic signed [31:0] off;
    bit rt_src, br, lu, hz, st, tk, e_pcs, e_j;
    mex_t n;
    #1;
    m  = mnem(m_ir);
    rs = m_ir[25:21]; rt = m_ir[20:16]; rd = m_ir[15:11];
    a  = rf_rd(rs);   b  = rf_rd(rt);
    rt_src = is_r(m) || m == "sw" || m == "beq" || m == "bne";
    br  = (m == "beq") || (m == "bne");
    lu  = m_ex.memread && (m_ex.waddr == rs || (rt_src && m_ex.waddr == rt));
    hz  = br && ((m_ex.regwrite && m_ex.waddr != 0 && (m_ex.waddr == rs || m_ex.waddr == rt)) ||
                 (mem_regwrite && mem_waddr != 0 && (mem_waddr == rs || mem_waddr == rt)));
    st  = lu || hz;
    tk  = (m == "beq" && a == b) || (m == "bne" && a != b);
    e_pcs = tk && !st;
    e_j   = (m == "j") && !st;
    off   = 32'($signed(m_ir[15:0]));
    btgt  = m_pc + off * 4;
    jtgt  = {m_pc[31:28], m_ir[25:0], 2'b00};
    e_pcc = e_j ? jtgt : btgt;

    chk("stall",    32'(stall), 32'(st));
    chk("PCSrc",    32'(PCSrc), 32'(e_pcs));
    chk("jump",     32'(jump),  32'(e_j));
    chk("pcchange", pcchange,   e_pcc);
    chk("ex_pcplus",  ex_pcplus,  m_ex.pcplus);
    chk("ex_rs_data", ex_rs_data, m_ex.rs_data);
    chk("ex_rt_data", ex_rt_data, m_ex.rt_data);
    chk("ex_imm",     ex_imm,     m_ex.imm);
    chk("ex_rs",      32'(ex_rs),    32'(m_ex.rs));
    chk("ex_rt",      32'(ex_rt),    32'(m_ex.rt));
    chk("ex_waddr",   32'(ex_waddr), 32'(m_ex.waddr));
    chk("ex_shamt",   32'(ex_shamt), 32'(m_ex.shamt));
    chk("ex_aluop",   32'(ex_aluop), 32'(m_ex.aluop));
    chk("ex_ctrl", {27'h0, ex_alusrc, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite},
                   {27'h0, m_ex.alusrc, m_ex.regwrite, m_ex.memtoreg, m_ex.memread, m_ex.memwrite});

    n.pcplus   = m_pc;
    n.rs_data  = a;
    n.rt_data  = b;
    n.imm      = (m == "andi" || m == "ori" || m == "lui") ? {16'h0, m_ir[15:0]} : off;
    n.rs       = rs;
    n.rt       = rt;
    n.shamt    = m_ir[10:6];
    n.regwrite = is_r(m) || i_dest(m);
    n.waddr    = is_r(m) ? rd : (i_dest(m) ? rt : 5'd0);
    n.aluop    = alu_of(m);
    n.alusrc   = i_dest(m) || m == "sw";
    n.memread  = (m == "lw");
    n.memtoreg = (m == "lw");
    n.memwrite = (m == "sw");

    @(posedge clk);
    if (rst) mreset();
    else begin
      if (wb_we && wb_waddr != 0) m_rf[wb_waddr] = wb_wdata;
      if (st) m_ex = '{default: 0};
      else begin
        m_ex = n;
        if (e_pcs || e_j) begin m_ir = 32'h0; m_pc = 32'h0; end
        else begin m_ir = irF; m_pc = pcplusF; end
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_ir();
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    int k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    sh  = 5'($urandom_range(0, 31));
    imm = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
    k   = int'($urandom_range(0, 22));
    if (k < 10) return {6'h00, rs, rt, rd, sh, ftab[k]};
    if (k < 21) return {otab[k-10], rs, rt, imm};
    if (k == 21) return 32'($urandom);
    return 32'h0;
  endfunction

  initial begin
    rst = 1'b1; irF = '0; pcplusF = '0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    mem_regwrite = 1'b0; mem_waddr = '0;
    repeat (2) @(posedge clk);
    #1;
    mreset();

    // reset state
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_pcchange", pcchange, 32'h0);
    chk("rst_ex_regwrite", 32'(ex_regwrite), 32'h0);
    chk("rst_ex_pcplus", ex_pcplus, 32'h0);
    rst = 1'b0;

    // addi $8,$0,5
    irF = 32'h2008_0005; pcplusF = 32'h4; cyc();
    irF = 32'h0; pcplusF = 32'h8; cyc();
    chk("addi_regwrite", 32'(ex_regwrite), 32'h1);
    chk("addi_alusrc", 32'(ex_alusrc), 32'h1);
    chk("addi_imm", ex_imm, 32'h5);
    chk("addi_waddr", 32'(ex_waddr), 32'd8);

    // load-use: lw $9,0($8); add $10,$9,$9
    irF = 32'h8D09_0000; pcplusF = 32'hC; cyc();
    irF = 32'h0129_5020; pcplusF = 32'h10; cyc();
    irF = 32'h0; #2;
    chk("lu_stall", 32'(stall), 32'h1);
    cyc();
    chk("lu_bubble", {30'h0, ex_regwrite, ex_memread}, 32'h0);
    #2;
    chk("lu_stall_once", 32'(stall), 32'h0);
    cyc();
    chk("lu_add_waddr", 32'(ex_waddr), 32'd10);
    chk("lu_add_regwrite", 32'(ex_regwrite), 32'h1);

    // beq $0,$0,+3 at pcplus 0x10
    irF = 32'h1000_0003; pcplusF = 32'h10; cyc();
    irF = 32'h2010_0077; pcplusF = 32'h14; #2;
    chk("beq_PCSrc", 32'(PCSrc), 32'h1);
    chk("beq_pcchange", pcchange, 32'h1C);
    cyc();
    irF = 32'h0; cyc();
    chk("beq_flush", 32'(ex_regwrite), 32'h0);

    // branch hazard on EX/MEM destination
    irF = 32'h1500_0001; pcplusF = 32'h20;
    wb_we = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'h5; cyc();
    wb_we = 1'b0; mem_regwrite = 1'b1; mem_waddr = 5'd8; irF = 32'h0; #2;
    chk("bh_stall", 32'(stall), 32'h1);
    chk("bh_PCSrc", 32'(PCSrc), 32'h0);
    cyc();
    mem_regwrite = 1'b0; #2;
    chk("bh_release", 32'(stall), 32'h0);
    chk("bh_PCSrc_late", 32'(PCSrc), 32'h1);
    chk("bh_pcchange", pcchange, 32'h24);
    cyc();

    // writeback write-through, and r0 stays zero
    irF = 32'h0060_2025; pcplusF = 32'h30; cyc();
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hDEAD_BEEF; irF = 32'h0; cyc();
    chk("wt_rs_data", ex_rs_data, 32'hDEAD_BEEF);
    chk("wt_waddr", 32'(ex_waddr), 32'd4);
    wb_waddr = 5'd0; wb_wdata = 32'h1234; cyc();
    chk("r0_rs_data", ex_rs_data, 32'h0);
    wb_we = 1'b0;

    // j with reset in the same cycle
    irF = 32'h0800_0040; pcplusF = 32'h8000_0010; cyc();
    irF = 32'h0; #2;
    chk("j_jump", 32'(jump), 32'h1);
    chk("j_pcchange", pcchange, 32'h8000_0100);
    rst = 1'b1; cyc();
    chk("jr_pcchange", pcchange, 32'h0);
    chk("jr_jump", 32'(jump), 32'h0);
    chk("jr_ex_pcplus", ex_pcplus, 32'h0);
    chk("jr_ex_regwrite", 32'(ex_regwrite), 32'h0);
    rst = 1'b0;

    // random streams
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      irF          = rnd_ir();
      pcplusF      = 32'($urandom) & ~32'h3;
      wb_we        = ($urandom_range(0, 1) == 1);
      wb_waddr     = 5'($urandom_range(0, 7));
      wb_wdata     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : 32'($urandom);
      mem_regwrite = ($urandom_range(0, 2) == 0);
      mem_waddr    = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
